binary_game_ctrl: RTL and testbench
===================================

# binary_game_ctrl

Round sequencer for the binary guessing game. Generates a pseudo-random 8-bit target and runs a per-round countdown. It samples the player's switch guess on a submit pulse and issues a one-cycle `is_equal` pulse and a `score_rst` pulse that drive the 4-bit score counter. It also ends the game after a fixed number of rounds. It sits between the debounced button/switch inputs and the score counter and display logic.

## Interface
- `ROUND_TIME`, 10: countdown length per round, in `tick` pulses (1..15).
- `NUM_ROUNDS`, 10: rounds per game (1..15; the score counter is 4 bits).
- `REVEAL_TICKS`, 2: `tick` pulses the result is held before the next round (1..15).
- `LFSR_SEED`, 8'hA5: LFSR value after reset; a seed of 0 is replaced by 8'h01.

- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle timebase enable (nominally 1 Hz).
- `start` in 1: one-cycle debounced start pulse.
- `submit` in 1: one-cycle debounced submit pulse.
- `guess` in 8: player switch value.
- `target` out 8: current target number.
- `is_equal` out 1: one-cycle pulse when a correct guess is scored; drives the score counter increment.
- `score_rst` out 1: one-cycle pulse that clears the score counter (OR'ed with `rst` at top level).
- `time_left` out 4: remaining ticks in the current round.
- `round` out 4: current round number, 1-based (0 before the first round).
- `playing` out 1: high in PLAY.
- `game_over` out 1: high in GAME_OVER.
- `last_correct` out 1: result of the most recent round.

## Operation
- Reset values:
  - state IDLE;
  - `target`=0, `time_left`=0, `round`=0;
  - `is_equal`=0, `score_rst`=0, `playing`=0, `game_over`=0, `last_correct`=0;
  - LFSR=`LFSR_SEED`.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts every clock in every state except during reset. It never reaches 0.
- States and transitions:
  - IDLE: `start` -> CLEAR.
  - CLEAR: `score_rst`=1, `round`<=0, `last_correct`<=0 -> NEW_ROUND unconditionally.
  - NEW_ROUND: `target`<=LFSR, `time_left`<=`ROUND_TIME`, `round`<=`round`+1 -> PLAY.
  - PLAY (`playing`=1), evaluated in this priority order:
    - `submit` with `guess`==`target`: `is_equal`=1 for one cycle, `last_correct`<=1 -> RESULT.
    - `submit` with a mismatch: `last_correct`<=0 -> RESULT. No retry.
    - `tick` with `time_left`==1: `time_left`<=0, `last_correct`<=0 -> RESULT (timeout).
    - `tick` otherwise: `time_left` decrements.
  - RESULT:
    - Reveal counter loads `REVEAL_TICKS` on entry and decrements on `tick`.
    - When it reaches 0: if `round`==`NUM_ROUNDS` -> GAME_OVER, else -> NEW_ROUND.
    - `target` and `time_left` hold their values.
  - GAME_OVER (`game_over`=1): `start` -> CLEAR. `target`, `round` and `last_correct` hold.
- Ignored inputs:
  - `start` is ignored outside IDLE and GAME_OVER.
  - `submit` is ignored outside PLAY.
  - `tick` is ignored outside PLAY and RESULT.
- Simultaneous events:
  - `submit` together with the final `tick`: the submit wins and is scored normally.
  - `start` together with `submit` in IDLE: only `start` acts.
- Reset mid-game: every output returns to its reset value on the next edge. Any pending `is_equal` is dropped.
- Widths: `round` never exceeds `NUM_ROUNDS`, and `time_left` never wraps below 0. Exactly one `is_equal` pulse is issued per round at most.

## Timing
- `start` sampled at edge k:
  - `score_rst`=1 during cycle k..k+1;
  - NEW_ROUND at k+1;
  - PLAY, with new `target`, `time_left` and `round`, after edge k+2.
- Correct `submit` sampled at edge k: `is_equal` is high for exactly cycle k..k+1, so the score counter increments at edge k+1. RESULT is entered at edge k.
- `time_left` updates on the same edge that samples `tick`.
- All outputs are registered or are decodes of the state register. No combinational path runs from inputs to outputs.

## Test plan
- Reset, then `start`: `score_rst` pulses once, `round`=1, `time_left`=10, `playing`=1 two cycles after `start`, and `target` is nonzero.
- In PLAY, drive `guess`=`target` and pulse `submit`:
  - `is_equal` is high for exactly one cycle and `last_correct`=1;
  - after 2 `tick`s, `round`=2 with a new `time_left`=10.
- Wrong guess, then a second `submit`: `is_equal` stays 0, `last_correct`=0, and the second `submit` has no effect (state is RESULT).
- No submit for 10 `tick`s: `time_left` counts 10 down to 0, then RESULT with `last_correct`=0. A `submit` on the same cycle as the 10th `tick` with a correct guess is scored.
- Full game with `NUM_ROUNDS`=3 and all rounds correct:
  - 3 `is_equal` pulses, then `game_over`=1 and `round`=3 held;
  - a following `start` pulses `score_rst` and gives `round`=1.
- Assert `rst` in PLAY on the cycle a correct `submit` arrives: no `is_equal` pulse, all outputs return to reset values, and the next `start` uses the LFSR restarted from 8'hA5.

Source files
------------

// File: rtl/binary_game_ctrl.sv
// Round sequencer for the binary guessing game: LFSR target generation,
// per-round countdown, guess scoring and fixed-length game control.
//
// state     | meaning
// IDLE      | waiting for the first start after reset
// CLEAR     | pulse score_rst, clear round and last_correct
// NEW_ROUND | latch LFSR as target, load countdown, advance round
// PLAY      | waiting for submit or countdown expiry
// RESULT    | hold the result for REVEAL_TICKS ticks
// GAME_OVER | all rounds played; waiting for start
module binary_game_ctrl #(
    parameter int         ROUND_TIME   = 10,
    parameter int         NUM_ROUNDS   = 10,
    parameter int         REVEAL_TICKS = 2,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       submit,
    input  logic [7:0] guess,
    output logic [7:0] target,
    output logic       is_equal,
    output logic       score_rst,
    output logic [3:0] time_left,
    output logic [3:0] round,
    output logic       playing,
    output logic       game_over,
    output logic       last_correct
);

    localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [3:0] RT = 4'(ROUND_TIME);
    localparam logic [3:0] NR = 4'(NUM_ROUNDS);
    localparam logic [3:0] RV = 4'(REVEAL_TICKS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        NEW_ROUND = 3'd2,
        PLAY      = 3'd3,
        RESULT    = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] lfsr;
    logic [3:0] reveal, reveal_nxt;
    logic [7:0] target_nxt;
    logic [3:0] time_nxt, round_nxt;
    logic       last_nxt, eq_nxt;

    // x^8+x^6+x^5+x^4+1: taps at bits 7,5,4,3; a nonzero seed never reaches 0
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED_EFF;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            target       <= 8'h00;
            time_left    <= 4'd0;
            round        <= 4'd0;
            reveal       <= 4'd0;
            last_correct <= 1'b0;
            is_equal     <= 1'b0;
        end else begin
            state        <= state_nxt;
            target       <= target_nxt;
            time_left    <= time_nxt;
            round        <= round_nxt;
            reveal       <= reveal_nxt;
            last_correct <= last_nxt;
            is_equal     <= eq_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        target_nxt = target;
        time_nxt   = time_left;
        round_nxt  = round;
        reveal_nxt = reveal;
        last_nxt   = last_correct;
        eq_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = CLEAR;
            end
            CLEAR: begin
                round_nxt = 4'd0;
                last_nxt  = 1'b0;
                state_nxt = NEW_ROUND;
            end
            NEW_ROUND: begin
                target_nxt = lfsr;
                time_nxt   = RT;
                round_nxt  = round + 4'd1;
                state_nxt  = PLAY;
            end
            PLAY: begin
                // submit outranks a simultaneous final tick
                if (submit) begin
                    eq_nxt     = (guess == target);
                    last_nxt   = (guess == target);
                    reveal_nxt = RV;
                    state_nxt  = RESULT;
                end else if (tick) begin
                    if (time_left <= 4'd1) begin
                        time_nxt   = 4'd0;
                        last_nxt   = 1'b0;
                        reveal_nxt = RV;
                        state_nxt  = RESULT;
                    end else begin
                        time_nxt = time_left - 4'd1;
                    end
                end
            end
            RESULT: begin
                if (tick) begin
                    if (reveal <= 4'd1) begin
                        reveal_nxt = 4'd0;
                        state_nxt  = (round >= NR) ? GAME_OVER : NEW_ROUND;
                    end else begin
                        reveal_nxt = reveal - 4'd1;
                    end
                end
            end
            GAME_OVER: begin
                if (start) state_nxt = CLEAR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign score_rst = (state == CLEAR);
    assign playing   = (state == PLAY);
    assign game_over = (state == GAME_OVER);

endmodule

// File: tb/tb_binary_game_ctrl.sv
// Randomized bench for binary_game_ctrl: round results are queued at stimulus
// time and popped by a monitor when the DUT leaves PLAY.
module tb_binary_game_ctrl;

    localparam int         RT   = 10;
    localparam int         NR   = 3;
    localparam int         RV   = 2;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       tick   = 1'b0;
    logic       start  = 1'b0;
    logic       submit = 1'b0;
    logic [7:0] guess  = 8'h00;
    logic [7:0] target;
    logic       is_equal, score_rst, playing, game_over, last_correct;
    logic [3:0] time_left, round;

    binary_game_ctrl #(
        .ROUND_TIME  (RT),
        .NUM_ROUNDS  (NR),
        .REVEAL_TICKS(RV),
        .LFSR_SEED   (SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start       (start),
        .submit      (submit),
        .guess       (guess),
        .target      (target),
        .is_equal    (is_equal),
        .score_rst   (score_rst),
        .time_left   (time_left),
        .round       (round),
        .playing     (playing),
        .game_over   (game_over),
        .last_correct(last_correct)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         rnd;
        logic [7:0] tgt;
        bit         correct;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_pass   = 0;
    int         n_checks = 0;
    int         n_edges  = 0;
    bit         prev_play = 1'b0;
    int         exp_round;
    logic [7:0] exp_tgt;

    // Shifts since the last reset edge; the DUT LFSR equals the seed advanced this many times.
    always @(posedge clk) begin
        if (rst) n_edges <= 0;
        else     n_edges <= n_edges + 1;
    end

    function automatic logic [7:0] lfsr_at(input int n);
        logic [7:0] v;
        v = SEED;
        for (int i = 0; i < n; i++) v = {v[6:0], ^(v & 8'hB8)};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("no_is_equal_in_reset", is_equal, 0);
            prev_play <= 1'b0;
        end else begin
            if (prev_play && !playing) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("is_equal_pulse", is_equal, mon_e.correct);
                    chk("last_correct", last_correct, mon_e.correct);
                    chk("result_round", round, mon_e.rnd);
                    chk("result_target", target, mon_e.tgt);
                end
            end else if (is_equal) begin
                chk("stray_is_equal", 1, 0);
            end
            prev_play <= playing;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit t, input bit s, input bit st, input logic [7:0] g);
        tick = t; submit = s; start = st; guess = g;
        step();
        tick = 1'b0; submit = 1'b0; start = 1'b0;
    endtask

    task automatic idle_rand(input int maxc);
        repeat ($urandom_range(0, maxc)) step();
    endtask

    task automatic check_reset_vals();
        chk("rst_target", target, 0);
        chk("rst_time_left", time_left, 0);
        chk("rst_round", round, 0);
        chk("rst_is_equal", is_equal, 0);
        chk("rst_score_rst", score_rst, 0);
        chk("rst_playing", playing, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_last_correct", last_correct, 0);
    endtask

    // Called just after the edge that enters NEW_ROUND.
    task automatic enter_round();
        exp_tgt = lfsr_at(n_edges);
        exp_round++;
        step();
        chk("round_playing", playing, 1);
        chk("round_number", round, exp_round);
        chk("round_time_left", time_left, RT);
        chk("round_target", target, exp_tgt);
        chk("target_nonzero", target != 8'h00, 1);
    endtask

    task automatic begin_game();
        pulse(1'b0, 1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
        chk("score_rst_on", score_rst, 1);
        chk("clear_not_playing", playing, 0);
        step();
        chk("score_rst_off", score_rst, 0);
        chk("round_cleared", round, 0);
        exp_round = 0;
        enter_round();
    endtask

    // mode: 0 correct, 1 wrong then retry, 2 timeout, 3 correct on final tick
    task automatic play_round(input int mode);
        int         ntk;
        logic [7:0] g;
        if (mode <= 1) begin
            ntk = $urandom_range(0, RT - 1);
            for (int i = 0; i < ntk; i++) begin
                idle_rand(2);
                pulse(1'b1, 1'b0, 1'b0, guess);
                chk("time_dec", time_left, RT - 1 - i);
            end
            idle_rand(2);
            g = (mode == 0) ? exp_tgt : exp_tgt ^ 8'($urandom_range(1, 255));
            sb.push_back('{exp_round, exp_tgt, mode == 0});
            pulse(1'b0, 1'b1, 1'b0, g);
            chk("left_play", playing, 0);
            if (mode == 1) begin
                pulse(1'b0, 1'b1, 1'b0, exp_tgt);
                chk("retry_last_correct", last_correct, 0);
                chk("retry_time_hold", time_left, RT - ntk);
                chk("retry_not_playing", playing, 0);
            end
        end else begin
            for (int i = 0; i < RT; i++) begin
                idle_rand(1);
                if (i == RT - 1) begin
                    sb.push_back('{exp_round, exp_tgt, mode == 3});
                    pulse(1'b1, mode == 3, 1'b0, exp_tgt);
                    chk("final_left_play", playing, 0);
                    chk("final_time_left", time_left, (mode == 3) ? 1 : 0);
                end else begin
                    pulse(1'b1, 1'b0, 1'b0, exp_tgt);
                    chk("timeout_dec", time_left, RT - 1 - i);
                end
            end
        end
        for (int r = 0; r < RV; r++) begin
            idle_rand(2);
            pulse(1'b1, 1'b0, 1'b0, guess);
            if (r < RV - 1) chk("reveal_hold", playing | game_over, 0);
        end
        if (exp_round < NR) begin
            chk("new_round_not_playing", playing, 0);
            enter_round();
        end else begin
            chk("game_over", game_over, 1);
            chk("game_over_round", round, NR);
            repeat (3) pulse(1'b1, 1'b1, 1'b0, exp_tgt);
            chk("game_over_held", game_over, 1);
            chk("game_over_round_held", round, NR);
            chk("game_over_target_held", target, exp_tgt);
        end
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check_reset_vals();
        pulse(1'b1, 1'b1, 1'b0, 8'h00);
        chk("idle_ignores_submit", playing, 0);
        chk("idle_ignores_tick", time_left, 0);

        begin_game();
        play_round(0);
        play_round(1);
        play_round(2);

        begin_game();
        play_round(3);
        play_round($urandom_range(0, 3));
        play_round($urandom_range(0, 3));

        begin_game();
        play_round(0);
        repeat ($urandom_range(0, 4)) pulse(1'b1, 1'b0, 1'b0, guess);
        rst = 1'b1; submit = 1'b1; guess = exp_tgt;
        step();
        submit = 1'b0;
        check_reset_vals();
        step();
        rst = 1'b0;
        repeat ($urandom_range(0, 5)) step();

        begin_game();
        play_round($urandom_range(0, 3));
        play_round($urandom_range(0, 3));
        play_round($urandom_range(0, 3));

        repeat (2) step();
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
